// File: rtl/sprite_compositor_if.sv
// Pixel-position request / composited-colour response bundle between the
// timing generator and the sprite compositor.
interface sprite_compositor_if;
  logic [10:0] i_H_pos;
  logic [9:0]  i_V_pos;
  logic        i_pos_valid;
  logic [23:0] o_color;
  logic        o_color_valid;

  modport master (output i_H_pos, i_V_pos, i_pos_valid,
                  input  o_color, o_color_valid);
  modport slave  (input  i_H_pos, i_V_pos, i_pos_valid,
                  output o_color, o_color_valid);
endinterface

// File: rtl/sprite_compositor.sv
// Bouncing-sprite compositor: 2-stage pixel pipeline plus a per-frame motion
// FSM that moves a rectangular sprite and reflects it off the screen edges.
module sprite_compositor #(
  parameter int H_SIZE   = 1600,
  parameter int V_SIZE   = 900,
  parameter int SPR_W    = 64,
  parameter int SPR_H    = 64,
  parameter int STEP     = 4,
  parameter int BORDER_W = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  sprite_compositor_if.slave   pix,
  input  logic [31:0]          i_frame_counter,
  input  logic                 i_start,
  input  logic                 i_pause,
  input  logic [23:0]          i_bg_color,
  input  logic [23:0]          i_spr_color,
  input  logic [23:0]          i_border_color,
  output logic [10:0]          o_spr_x,
  output logic [9:0]           o_spr_y,
  output logic [15:0]          o_bounce_count,
  output logic [1:0]           o_state
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam int STAGES = 2;

  localparam logic [10:0] X_RST  = 11'((H_SIZE - SPR_W) / 2);
  localparam logic [9:0]  Y_RST  = 10'((V_SIZE - SPR_H) / 2);
  localparam logic [10:0] X_MAX  = 11'(H_SIZE - SPR_W);
  localparam logic [9:0]  Y_MAX  = 10'(V_SIZE - SPR_H);
  localparam logic [10:0] X_STEP = 11'(STEP);
  localparam logic [9:0]  Y_STEP = 10'(STEP);
  localparam logic [11:0] X_ADV  = 12'(STEP + SPR_W);
  localparam logic [10:0] Y_ADV  = 11'(STEP + SPR_H);

  logic [1:0]  state_q, state_d;
  logic [31:0] fc_q;
  logic        frame_evt, move;
  logic [10:0] x_q, x_d, sx_l;
  logic [9:0]  y_q, y_d, sy_l;
  logic        dx_q, dx_d, dy_q, dy_d, bx, by;
  logic [15:0] cnt_q, cnt_d;
  logic [16:0] cnt_sum;

  assign frame_evt = (i_frame_counter != fc_q);
  // Motion uses the state held before this cycle's transition.
  assign move      = frame_evt && (state_q == S_RUN);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_start && !i_pause) state_d = S_RUN;
      S_RUN:   if (i_pause)             state_d = S_PAUSE;
      S_PAUSE: if (i_start && !i_pause) state_d = S_RUN;
      default:                          state_d = S_IDLE;
    endcase
  end

  always_comb begin
    x_d = x_q; dx_d = dx_q; bx = 1'b0;
    y_d = y_q; dy_d = dy_q; by = 1'b0;
    if (dx_q) begin
      if ({1'b0, x_q} + X_ADV > 12'(H_SIZE)) begin
        x_d = X_MAX; dx_d = 1'b0; bx = 1'b1;
      end else x_d = x_q + X_STEP;
    end else if (x_q < X_STEP) begin
      x_d = '0; dx_d = 1'b1; bx = 1'b1;
    end else x_d = x_q - X_STEP;
    if (dy_q) begin
      if ({1'b0, y_q} + Y_ADV > 11'(V_SIZE)) begin
        y_d = Y_MAX; dy_d = 1'b0; by = 1'b1;
      end else y_d = y_q + Y_STEP;
    end else if (y_q < Y_STEP) begin
      y_d = '0; dy_d = 1'b1; by = 1'b1;
    end else y_d = y_q - Y_STEP;
    cnt_sum = {1'b0, cnt_q} + 17'(bx) + 17'(by);
    cnt_d   = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      fc_q    <= '0;
      x_q     <= X_RST;
      y_q     <= Y_RST;
      dx_q    <= 1'b1;
      dy_q    <= 1'b1;
      cnt_q   <= '0;
      sx_l    <= X_RST;
      sy_l    <= Y_RST;
    end else begin
      state_q <= state_d;
      fc_q    <= i_frame_counter;
      if (move) begin
        x_q <= x_d; dx_q <= dx_d;
        y_q <= y_d; dy_q <= dy_d;
        cnt_q <= cnt_d;
      end
      // Pixel pipeline only sees the position at frame boundaries: no tearing.
      if (frame_evt) begin
        sx_l <= move ? x_d : x_q;
        sy_l <= move ? y_d : y_q;
      end
    end
  end

  assign o_spr_x        = x_q;
  assign o_spr_y        = y_q;
  assign o_bounce_count = cnt_q;
  assign o_state        = state_q;

  // Pixel pipeline: stage 1 classifies, stage 2 selects the colour.
  logic [STAGES:0] vld_pipe;
  logic            hit_spr, hit_bdr, s1_spr, s1_bdr;

  assign vld_pipe[0] = pix.i_pos_valid && (pix.i_H_pos < 11'(H_SIZE)) &&
                       (pix.i_V_pos < 10'(V_SIZE));
  assign hit_spr = ({1'b0, pix.i_H_pos} >= {1'b0, sx_l}) &&
                   ({1'b0, pix.i_H_pos} <  {1'b0, sx_l} + 12'(SPR_W)) &&
                   ({1'b0, pix.i_V_pos} >= {1'b0, sy_l}) &&
                   ({1'b0, pix.i_V_pos} <  {1'b0, sy_l} + 11'(SPR_H));
  assign hit_bdr = (pix.i_H_pos <  11'(BORDER_W)) ||
                   (pix.i_H_pos >= 11'(H_SIZE - BORDER_W)) ||
                   (pix.i_V_pos <  10'(BORDER_W)) ||
                   (pix.i_V_pos >= 10'(V_SIZE - BORDER_W));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_pipe[STAGES:1] <= '0;
      s1_spr             <= 1'b0;
      s1_bdr             <= 1'b0;
      pix.o_color        <= '0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      s1_spr             <= vld_pipe[0] && hit_spr;
      s1_bdr             <= vld_pipe[0] && hit_bdr;
      if (!vld_pipe[1])  pix.o_color <= '0;
      else if (s1_spr)   pix.o_color <= i_spr_color;
      else if (s1_bdr)   pix.o_color <= i_border_color;
      else               pix.o_color <= i_bg_color;
    end
  end

  assign pix.o_color_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor: scoreboarded pixel colours, motion
// model for position/bounces, FSM corner cases, reset and counter saturation.
module tb_sprite_compositor;
  localparam logic [23:0] BG = 24'h102030, SPR = 24'hF0E0D0, BDR = 24'h00FF00;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] fc = '0, fc2 = '0;
  logic        start = 1'b0, pause = 1'b0, start2 = 1'b0;
  logic [10:0] spr_x, spr_x2;
  logic [9:0]  spr_y, spr_y2;
  logic [15:0] bcnt, bcnt2;
  logic [1:0]  st, st2;

  sprite_compositor_if pif ();
  sprite_compositor_if pif2 ();

  always #5 clk = ~clk;

  sprite_compositor dut (
    .i_clk(clk), .i_rst_n(rst_n), .pix(pif.slave), .i_frame_counter(fc),
    .i_start(start), .i_pause(pause), .i_bg_color(BG), .i_spr_color(SPR),
    .i_border_color(BDR), .o_spr_x(spr_x), .o_spr_y(spr_y),
    .o_bounce_count(bcnt), .o_state(st));

  // Tiny screen where the sprite hits a corner on every frame.
  sprite_compositor #(.H_SIZE(6), .V_SIZE(6), .SPR_W(4), .SPR_H(4), .STEP(4),
                      .BORDER_W(1)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .pix(pif2.slave), .i_frame_counter(fc2),
    .i_start(start2), .i_pause(1'b0), .i_bg_color(BG), .i_spr_color(SPR),
    .i_border_color(BDR), .o_spr_x(spr_x2), .o_spr_y(spr_y2),
    .o_bounce_count(bcnt2), .o_state(st2));

  int n_vec = 0, n_err = 0;
  logic [24:0] sb[$];
  int mx, my, mcnt, mst;
  bit mdx, mdy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // One pixel per cycle; expected result queued now, checked two cycles later.
  task automatic cyc(input int h, input int v, input logic pv, input logic ev, input logic [23:0] ec);
    logic [24:0] e;
    @(negedge clk);
    if (sb.size() >= 2) begin
      e = sb.pop_front();
      chk("color_valid", {31'b0, pif.o_color_valid}, {31'b0, e[24]});
      chk("color", {8'b0, pif.o_color}, {8'b0, e[23:0]});
    end
    pif.i_H_pos = 11'(h); pif.i_V_pos = 10'(v); pif.i_pos_valid = pv;
    sb.push_back({ev, ec});
  endtask

  task automatic flush();
    repeat (2) cyc(0, 0, 1'b0, 1'b0, 24'h0);
    sb.delete();
  endtask

  task automatic model_step();
    if (mdx) begin
      if (mx + 4 + 64 > 1600) begin mx = 1536; mdx = 0; mcnt++; end else mx += 4;
    end else if (mx < 4) begin mx = 0; mdx = 1; mcnt++; end else mx -= 4;
    if (mdy) begin
      if (my + 4 + 64 > 900) begin my = 836; mdy = 0; mcnt++; end else my += 4;
    end else if (my < 4) begin my = 0; mdy = 1; mcnt++; end else my -= 4;
    if (mcnt > 65535) mcnt = 65535;
  endtask

  task automatic frame(input bit check);
    @(negedge clk); fc = fc + 1;
    @(posedge clk); if (mst == 1) model_step();
    @(negedge clk);
    if (check) begin
      chk("spr_x", 32'(spr_x), 32'(mx));
      chk("spr_y", 32'(spr_y), 32'(my));
      chk("bounce", 32'(bcnt), 32'(mcnt));
    end
  endtask

  task automatic pulse(input logic s, input logic p);
    @(negedge clk); start = s; pause = p;
    @(posedge clk);
    case (mst)
      0: if (s && !p) mst = 1;
      1: if (p)       mst = 2;
      2: if (s && !p) mst = 1;
      default: mst = 0;
    endcase
    @(negedge clk); start = 0; pause = 0;
    chk("state", 32'(st), 32'(mst));
  endtask

  initial begin
    pif.i_H_pos = '0; pif.i_V_pos = '0; pif.i_pos_valid = 1'b0;
    pif2.i_H_pos = '0; pif2.i_V_pos = '0; pif2.i_pos_valid = 1'b0;
    mx = 768; my = 418; mdx = 1; mdy = 1; mcnt = 0; mst = 0;

    #12;
    chk("rst_valid", {31'b0, pif.o_color_valid}, 32'd0);
    chk("rst_color", {8'b0, pif.o_color}, 32'd0);
    chk("rst_state", 32'(st), 32'd0);
    chk("rst_x", 32'(spr_x), 32'd768);
    chk("rst_y", 32'(spr_y), 32'd418);
    chk("rst_bounce", 32'(bcnt), 32'd0);
    chk("rst_x_small", 32'(spr_x2), 32'd1);
    @(negedge clk); rst_n = 1'b1;

    // Colour priority and out-of-range qualification.
    cyc(768, 418, 1, 1, SPR);
    cyc(100, 100, 1, 1, BG);
    cyc(3,   500, 1, 1, BDR);
    cyc(1600, 5,  1, 0, 24'h0);
    cyc(5,   900, 1, 0, 24'h0);
    cyc(831, 481, 1, 1, SPR);
    cyc(832, 418, 1, 1, BG);
    cyc(767, 481, 1, 1, BG);
    cyc(768, 482, 1, 1, BG);
    cyc(1599, 450, 1, 1, BDR);
    cyc(1592, 5,  1, 1, BDR);
    cyc(800, 895, 1, 1, BDR);
    cyc(768, 418, 0, 0, 24'h0);
    flush();

    // Start / pause / resume motion.
    pulse(1, 0);
    repeat (3) frame(1);
    chk("run3_x", 32'(spr_x), 32'd780);
    chk("run3_y", 32'(spr_y), 32'd430);
    pulse(0, 1);
    repeat (2) frame(1);
    chk("pause_x", 32'(spr_x), 32'd780);
    pulse(1, 0);
    frame(1);
    chk("resume_x", 32'(spr_x), 32'd784);
    chk("resume_y", 32'(spr_y), 32'd434);

    pulse(1, 1);
    chk("both_run", 32'(st), 32'd2);
    pulse(1, 1);
    chk("both_pause", 32'(st), 32'd2);
    pulse(1, 0);

    // Ride into the bottom wall, then the right wall.
    repeat (200) frame(1);
    chk("wall_x", 32'(spr_x), 32'd1492);
    chk("wall_y", 32'(spr_y), 32'd440);
    chk("wall_bounce", 32'(bcnt), 32'd2);

    // Moved sprite is what the pixel pipeline now draws.
    pulse(0, 1);
    cyc(mx, my, 1, 1, SPR);
    cyc(mx - 1, my, 1, 1, BG);
    cyc(768, 418, 1, 1, BG);
    flush();

    @(negedge clk);
    force dut.state_q = 2'd3;
    #1 chk("forced_state", 32'(st), 32'd3);
    release dut.state_q;
    @(posedge clk); #1;
    chk("illegal_to_idle", 32'(st), 32'd0);
    mst = 0;

    // Reset while pixels are streaming.
    repeat (3) begin
      @(negedge clk); pif.i_H_pos = 11'd100; pif.i_V_pos = 10'd100; pif.i_pos_valid = 1'b1;
    end
    @(negedge clk);
    chk("pre_rst_valid", {31'b0, pif.o_color_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'b0, pif.o_color_valid}, 32'd0);
    chk("mid_rst_color", {8'b0, pif.o_color}, 32'd0);
    chk("mid_rst_x", 32'(spr_x), 32'd768);
    chk("mid_rst_y", 32'(spr_y), 32'd418);
    pif.i_pos_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;

    // Corner bounces every frame on the tiny screen; counter saturates.
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0; fc2 = fc2 + 1;
    @(negedge clk);
    chk("corner_x", 32'(spr_x2), 32'd2);
    chk("corner_y", 32'(spr_y2), 32'd2);
    chk("corner_cnt", 32'(bcnt2), 32'd2);
    fc2 = fc2 + 1;
    @(negedge clk);
    chk("left_x", 32'(spr_x2), 32'd0);
    chk("left_cnt", 32'(bcnt2), 32'd4);
    for (int i = 0; i < 32765; i++) begin
      fc2 = fc2 + 1;
      @(negedge clk);
    end
    @(negedge clk);
    chk("cnt_fffe", 32'(bcnt2), 32'h0000FFFE);
    fc2 = fc2 + 1;
    @(negedge clk);
    chk("cnt_sat", 32'(bcnt2), 32'h0000FFFF);
    fc2 = fc2 + 1;
    @(negedge clk);
    chk("cnt_hold", 32'(bcnt2), 32'h0000FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
